// File: rtl/riscv_pkg.sv
// Shared opcode, FSM-state and control-encoding definitions for the multicycle core.
// MCCTRL_JALR_EN adds the JALRADR state to the state enum.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
`ifdef MCCTRL_JALR_EN
    S_JAL,
    S_JALRADR
`else
    S_JAL
`endif
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// ALU-control sub-decoder: maps ALUOp and instruction fields to an ALU operation.
// Purely combinational.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_ctl = ALU_ADD;
    unique case (funct3)
      3'b000:  funct_ctl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctl = ALU_SLT;
      3'b110:  funct_ctl = ALU_OR;
      3'b111:  funct_ctl = ALU_AND;
      default: funct_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      alu_op == ALUOP_SUB:   alu_control = ALU_SUB;
      alu_op == ALUOP_FUNCT: alu_control = funct_ctl;
      default:               alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle RV32I core.
// Define MCCTRL_JALR_EN to add JALR support via the JALRADR state.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       retire,
  output logic       illegal
);

  state_t     state;
  state_t     next;
  logic       ready;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       ir_w;
  logic       mem_w;
  logic       reg_w;
  logic       ret;
  logic       ill;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = ALUOP_ADD;
    ir_w      = 1'b0;
    mem_w     = 1'b0;
    reg_w     = 1'b0;
    ret       = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    unique case (state)
      S_FETCH: begin
        ResultSrc = RES_ALURESULT;
        ALUSrcB   = SRCB_FOUR;
        ir_w      = ready;
        pc_update = ready;
        if (ready) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          op == OP_LOAD,
          op == OP_STORE:  next = S_MEMADR;
          op == OP_RTYPE:  next = S_EXECR;
          op == OP_ITYPE:  next = S_EXECI;
          op == OP_BRANCH: next = S_BEQ;
          op == OP_JAL:    next = S_JAL;
`ifdef MCCTRL_JALR_EN
          op == OP_JALR:   next = S_JALRADR;
`endif
          default: begin
            next = S_FETCH;
            ill  = 1'b1;
            ret  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        ret       = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        ret    = ready;
        if (ready) next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        ret   = 1'b1;
        next  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        ret     = 1'b1;
        next    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        next      = S_ALUWB;
      end
`ifdef MCCTRL_JALR_EN
      S_JALRADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        next    = S_JAL;
      end
`endif
      default: next = S_FETCH;
    endcase
    // Reset overrides: no writes, muxes parked at their fetch settings
    if (rst) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_w      = 1'b0;
      mem_w     = 1'b0;
      reg_w     = 1'b0;
      ret       = 1'b0;
      ill       = 1'b0;
      alu_op    = ALUOP_ADD;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
    end
  end

  assign PCWrite  = pc_update | (branch & zero);
  assign IRWrite  = ir_w;
  assign MemWrite = mem_w;
  assign RegWrite = reg_w;
  assign retire   = ret;
  assign illegal  = ill;

  always_comb begin
    ImmSrc = IMM_I;
    unique case (1'b1)
      op == OP_STORE:  ImmSrc = IMM_S;
      op == OP_BRANCH: ImmSrc = IMM_B;
      op == OP_JAL:    ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step-list reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       retire;
  logic       illegal;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .retire     (retire),
    .illegal    (illegal)
  );

  int checks = 0;
  int failures = 0;

  // step kinds of an instruction's cycle list
  localparam int F = 0, D = 1, ADR = 2, RD = 3, MWB = 4, WR = 5;
  localparam int EXR = 6, EXI = 7, WB = 8, BR = 9, J = 10, JADR = 11;

  int path[$];
  int len_cnt = 0;
  int last_len = 0;
  int mw_cnt = 0;

  logic       g_pcw, g_mw, g_irw, g_rw, g_ret, g_ill;
  logic [1:0] g_res;
  logic [2:0] g_alu;

  function automatic bit is_legal(input logic [6:0] o);
    case (o)
      7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f: return 1'b1;
`ifdef MCCTRL_JALR_EN
      7'h67: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu();
    case (funct3)
      3'd0:    return (op[5] && funct7b5) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,retire,illegal}
  function automatic logic [17:0] expect_vec(input int s, input logic rdy,
                                             input logic z, input logic r);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ret = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0, imm = 0;
    logic [2:0] alu = 0;
    imm = (op == 7'h23) ? 2'd1 : (op == 7'h63) ? 2'd2 : (op == 7'h6f) ? 2'd3 : 2'd0;
    case (s)
      F:    begin res = 2; b = 2; pcw = rdy; irw = rdy; end
      D:    begin a = 1; b = 1; ill = !is_legal(op); ret = ill; end
      ADR:  begin a = 2; b = 1; end
      RD:   adr = 1;
      MWB:  begin res = 1; rw = 1; ret = 1; end
      WR:   begin adr = 1; mw = 1; ret = rdy; end
      EXR:  begin a = 2; b = 0; alu = funct_alu(); end
      EXI:  begin a = 2; b = 1; alu = funct_alu(); end
      WB:   begin rw = 1; ret = 1; end
      BR:   begin a = 2; alu = 3'd1; pcw = z; ret = 1; end
      J:    begin a = 1; b = 2; pcw = 1; end
      JADR: begin a = 2; b = 1; end
      default: ;
    endcase
    if (r) begin
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ret = 0; ill = 0;
      res = 2; a = 0; b = 2; alu = 0;
    end
    return {pcw, adr, mw, irw, rw, res, a, b, imm, alu, ret, ill};
  endfunction

  task automatic advance(input logic rdy, input logic r);
    int s;
    if (r) begin
      path = {};
      path.push_back(F);
      return;
    end
    s = path[0];
    if ((s == F || s == RD || s == WR) && !rdy) return;
    void'(path.pop_front());
    if (s == F) begin
      path.push_back(D);
      case (op)
        7'h03: begin path.push_back(ADR); path.push_back(RD); path.push_back(MWB); end
        7'h23: begin path.push_back(ADR); path.push_back(WR); end
        7'h33: begin path.push_back(EXR); path.push_back(WB); end
        7'h13: begin path.push_back(EXI); path.push_back(WB); end
        7'h63: path.push_back(BR);
        7'h6f: begin path.push_back(J); path.push_back(WB); end
`ifdef MCCTRL_JALR_EN
        7'h67: begin path.push_back(JADR); path.push_back(J); path.push_back(WB); end
`endif
        default: ;
      endcase
    end
    if (path.size() == 0) path.push_back(F);
  endtask

  // one clock: drive at negedge, compare 1ns later, step the model
  task automatic cycle(input logic r, input logic rdy, input logic z);
    logic [17:0] got, exp;
    rst = r; mem_ready = rdy; zero = z;
    #1;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, ALUControl, retire, illegal};
    exp = expect_vec(path[0], rdy, z, r);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle t=%0t step=%0d op=%h got=%b required=%b",
               $time, path[0], op, got, exp);
    end
    {g_pcw, g_mw, g_irw, g_rw, g_ret, g_ill} =
      {PCWrite, MemWrite, IRWrite, RegWrite, retire, illegal};
    g_res = ResultSrc;
    g_alu = ALUControl;
    mw_cnt = MemWrite ? mw_cnt + 1 : 0;
    if (r) len_cnt = 0;
    else begin
      len_cnt++;
      if (exp[1]) begin
        last_len = len_cnt;
        len_cnt = 0;
      end
    end
    advance(rdy, r);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    rst = 1; op = 7'h33; funct3 = 0; funct7b5 = 1; zero = 0; mem_ready = 1;
    path.push_back(F);
    @(negedge clk);

    // reset, then sub (R-type)
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("rst_irwrite", g_irw, 0);
    chk("rst_resultsrc", g_res, 2);
    cycle(0, 1, 0);
    chk("r_fetch_irwrite", g_irw, 1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("r_exec_alu", g_alu, 1);
    cycle(0, 1, 0);
    chk("r_wb", {g_rw, g_ret}, 3);
    chk("r_len", last_len, 4);

    // lw with two wait cycles
    op = 7'h03; funct3 = 3'd2;
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("lw_wb", {g_res, g_rw}, 3);
    chk("lw_len", last_len, 7);

    // sw with three wait cycles
    op = 7'h23;
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    chk("sw_wait_retire", g_ret, 0);
    cycle(0, 1, 0);
    chk("sw_ready_retire", g_ret, 1);
    chk("sw_memwrite_run", mw_cnt, 4);

    // beq taken / not taken
    op = 7'h63; funct3 = 0;
    cycle(0, 1, 1); cycle(0, 1, 1); cycle(0, 1, 1);
    chk("beq_taken", g_pcw, 1);
    chk("beq_taken_len", last_len, 3);
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    chk("beq_not_taken", g_pcw, 0);
    chk("beq_nt_len", last_len, 3);

    // jalr
    op = 7'h67;
`ifdef MCCTRL_JALR_EN
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("jalr_pcwrite", g_pcw, 1);
    cycle(0, 1, 0);
    chk("jalr_regwrite", g_rw, 1);
    chk("jalr_len", last_len, 5);
`else
    cycle(0, 1, 0); cycle(0, 1, 0);
    chk("jalr_illegal", {g_ill, g_ret}, 3);
    cycle(0, 0, 0);
    chk("jalr_back_fetch", g_res, 2);
`endif

    // reset while waiting in MEMWRITE
    op = 7'h23;
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(0, 0, 0);
    chk("abort_pre_mw", g_mw, 1);
    cycle(1, 0, 0);
    chk("abort_rst_mw", g_mw, 0);
    cycle(0, 0, 0);
    chk("abort_post_mw", g_mw, 0);
    chk("abort_post_fetch", g_res, 2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, rdy, z;
      if (path[0] == F) begin
        case ($urandom_range(0, 8))
          0: op = 7'h03;
          1: op = 7'h23;
          2: op = 7'h33;
          3: op = 7'h13;
          4: op = 7'h63;
          5: op = 7'h6f;
          6: op = 7'h67;
          7: op = 7'h33;
          default: op = 7'($urandom);
        endcase
        funct3 = 3'($urandom);
        funct7b5 = 1'($urandom);
      end
      r = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      z = 1'($urandom);
      cycle(r, rdy, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core; successor to the single-cycle decoder. It sequences each instruction through a Moore FSM, driving PC, IR, memory, ALU-mux and register-file enables cycle by cycle, and optionally waits on a memory ready handshake. It sits between the instruction register and the shared-memory datapath, with an ALU-control sub-decoder.

## Interface
- MEM_HANDSHAKE, 1, 1: FETCH, MEMREAD and MEMWRITE hold until `mem_ready`; 0: `mem_ready` is ignored and treated as 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC load.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from `op`.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- retire  out  1  one-cycle pulse in the last cycle of every instruction.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, plus JALRADR when the JALR feature is enabled.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when `mem_ready`. The FSM moves to DECODE on `mem_ready` and otherwise stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; this computes the branch/jump target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with `illegal`=1 and `retire`=1
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next state is MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Moves to MEMWB on `mem_ready`.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in this state. On `mem_ready`: retire=1, next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Next state ALUWB; rd receives OldPC+4.
- PCWrite = PCUpdate | (Branch & zero).
- ALUControl decode:
  - ALUOp 00 → add
  - ALUOp 01 → sub
  - ALUOp 10, by funct3:
    - 000 → sub if {op[5],funct7b5}=11, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → add
- Unlisted mux outputs are 00 (AdrSrc 0). Enables are 0 in every state where they are not listed.

## Timing
- Reset: the state register loads FETCH on the first edge with `rst`=1. While `rst`=1, PCWrite, IRWrite, MemWrite, RegWrite, retire and illegal are forced to 0; the mux outputs take their FETCH values.
- Reset asserted mid-instruction aborts it: no write enables are asserted from the reset edge onward.
- All outputs are Moore (decoded from state, op, funct3, funct7b5), except IRWrite, PCWrite and MemWrite-stage retire, which are qualified by `mem_ready` or `zero` in the same cycle.
- Cycle counts with `mem_ready` held high: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, jalr 5.
- Each cycle `mem_ready` is low in a wait state adds exactly one cycle.

## Configuration
- `MCCTRL_JALR_EN` defined:
  - opcode 1100111 goes DECODE → JALRADR.
  - JALRADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; next state JAL.
  - The JAL state then loads PC ← rs1+imm and ALUWB writes OldPC+4.
- Undefined: 1100111 is illegal, and the JALRADR state is not present.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants
  - the state enum typedef
  - the ResultSrc/ALUSrcA/ALUSrcB/ImmSrc/ALUControl encodings
- The ALU-control mapping is a separate combinational sub-module `alu_decoder` (inputs ALUOp, funct3, op[5], funct7b5).

## Test plan
- rst high 2 cycles then low, op=0110011, funct3=000, funct7b5=1, mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; ALUControl=001 in EXECR; RegWrite and retire high in cycle 4 only.
- lw (op=0000011) with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; ResultSrc=01 and RegWrite=1 in MEMWB.
- sw (op=0100011) with MEMWRITE and mem_ready=0 for 3 cycles → MemWrite high for 4 consecutive cycles; retire only on the ready cycle.
- beq with zero=1 then with zero=0 → PCWrite=1 in BEQ for the first only; both take 3 cycles.
- op=1100111 → with `MCCTRL_JALR_EN`: 5 cycles, PCWrite in JAL, RegWrite in ALUWB. Without it: illegal=1 in DECODE, next state FETCH.
- rst asserted while in MEMWRITE with mem_ready=0 → MemWrite=0 from that edge onward; state FETCH after it.
